// File: rtl/dct_pkg.sv
// Shared constants for the 8-point DCT datapath: FSM encoding, Q1.7 cosine
// table and the rounding constants used when dropping the fraction bits.
package dct_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } dct_state_t;

    localparam int DCT_CWIDTH = 8;
    localparam int DCT_FRAC   = 7;
    localparam int DCT_RND    = 64;

    // C[k][n] = round(128 * c(k)/2 * cos((2n+1)k*pi/16)), c(0) = 1/sqrt(2)
    localparam logic signed [DCT_CWIDTH-1:0] DCT_COS [0:7][0:7] = '{
        '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
        '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
        '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
        '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
        '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
        '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
        '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
        '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
    };

endpackage

// File: rtl/dct_cos_rom.sv
// Combinational cosine lookup indexed by coefficient row k and sample column n.
module dct_cos_rom
    import dct_pkg::*;
(
    input  logic [2:0]                   i_k,
    input  logic [2:0]                   i_n,
    output logic signed [DCT_CWIDTH-1:0] o_coef
);

    assign o_coef = DCT_COS[i_k][i_n];

endmodule

// File: rtl/dct_row_mac8.sv
// Serial 8-point 1-D DCT: one MAC per cycle over a latched sample vector,
// one rounded/saturated coefficient presented per output handshake.
module dct_row_mac8
    import dct_pkg::*;
#(
    parameter int WIDTH  = 11,
    parameter int CWIDTH = 8,
    parameter int OWIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  x0,
    input  logic signed [WIDTH-1:0]  x1,
    input  logic signed [WIDTH-1:0]  x2,
    input  logic signed [WIDTH-1:0]  x3,
    input  logic signed [WIDTH-1:0]  x4,
    input  logic signed [WIDTH-1:0]  x5,
    input  logic signed [WIDTH-1:0]  x6,
    input  logic signed [WIDTH-1:0]  x7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OWIDTH-1:0] dout,
    output logic [2:0]               kidx,
    output logic                     last
);

    localparam int PW = WIDTH + CWIDTH;
    localparam int AW = WIDTH + CWIDTH + 3;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 <<< (OWIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 <<< (OWIDTH - 1)));

    dct_state_t r_state;
    dct_state_t w_state_nxt;

    logic signed [WIDTH-1:0]  r_x [8];
    logic [2:0]               r_k;
    logic [2:0]               r_n;
    logic signed [AW-1:0]     r_acc;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic signed [OWIDTH-1:0] r_dout;
    logic [2:0]               r_kidx;
    logic                     r_last;

    logic                       w_accept;
    logic signed [WIDTH-1:0]    w_xn;
    logic signed [CWIDTH-1:0]   w_coef;
    logic signed [PW-1:0]       w_prod;
    logic signed [AW-1:0]       w_acc_base;
    logic signed [AW-1:0]       w_sum;
    logic signed [AW-1:0]       w_rnd;
    logic signed [OWIDTH-1:0]   w_sat;

    dct_cos_rom u_rom (
        .i_k    (r_k),
        .i_n    (r_n),
        .o_coef (w_coef)
    );

    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_xn       = r_x[r_n];
    assign w_prod     = w_xn * w_coef;
    assign w_acc_base = (r_n == 3'd0) ? '0 : r_acc;
    assign w_sum      = w_acc_base + AW'(w_prod);
    assign w_rnd      = (w_sum + AW'(DCT_RND)) >>> DCT_FRAC;
    assign w_sat      = (w_rnd > SAT_MAX) ? SAT_MAX[OWIDTH-1:0] :
                        (w_rnd < SAT_MIN) ? SAT_MIN[OWIDTH-1:0] :
                                            w_rnd[OWIDTH-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_state_nxt = MAC;
            MAC:     if (r_n == 3'd7)     w_state_nxt = HOLD;
            HOLD:    if (out_ready)       w_state_nxt = (r_k == 3'd7) ? IDLE : MAC;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_k         <= 3'd0;
            r_n         <= 3'd0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_kidx      <= 3'd0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == HOLD);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_k <= 3'd0;
                        r_n <= 3'd0;
                    end
                end
                MAC: begin
                    r_acc <= w_sum;
                    r_n   <= r_n + 3'd1;
                    if (r_n == 3'd7) begin
                        r_dout <= w_sat;
                        r_kidx <= r_k;
                        r_last <= (r_k == 3'd7);
                    end
                end
                HOLD: begin
                    if (out_ready && r_k != 3'd7) begin
                        r_k <= r_k + 3'd1;
                        r_n <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sample registers carry no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x[0] <= x0;
            r_x[1] <= x1;
            r_x[2] <= x2;
            r_x[3] <= x3;
            r_x[4] <= x4;
            r_x[5] <= x5;
            r_x[6] <= x6;
            r_x[7] <= x7;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign kidx      = r_kidx;
    assign last      = r_last;

endmodule

// File: tb/tb_dct_row_mac8.sv
// Directed bench for dct_row_mac8: hand-computed vectors, stall, mid-block
// reset, back-to-back blocks against an integer and a floating-point model.
module tb_dct_row_mac8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic signed [10:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic              out_valid;
    logic              out_ready;
    logic signed [11:0] dout;
    logic [2:0]        kidx;
    logic              last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dct_row_mac8 dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .x5        (x5),
        .x6        (x6),
        .x7        (x7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .kidx      (kidx),
        .last      (last)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cos_ref(input int k, input int n);
        real v;
        v = 64.0 * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0);
        if (k == 0) v = v / $sqrt(2.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int model(input int xs[8], input int k);
        int acc;
        int r;
        acc = 0;
        for (int n = 0; n < 8; n++) acc += xs[n] * cos_ref(k, n);
        r = (acc + 64) >>> 7;
        if (r > 2047)  r = 2047;
        if (r < -2048) r = -2048;
        return r;
    endfunction

    function automatic real float_dct(input int xs[8], input int k);
        real s;
        s = 0.0;
        for (int n = 0; n < 8; n++)
            s += xs[n] * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0);
        s = s / 2.0;
        if (k == 0) s = s / $sqrt(2.0);
        return s;
    endfunction

    task automatic set_x(input int xs[8]);
        x0 = 11'(xs[0]); x1 = 11'(xs[1]); x2 = 11'(xs[2]); x3 = 11'(xs[3]);
        x4 = 11'(xs[4]); x5 = 11'(xs[5]); x6 = 11'(xs[6]); x7 = 11'(xs[7]);
    endtask

    // Called at a negedge; returns at the negedge after the X7 handshake.
    task automatic run_block(input int xs[8], input int ex[8], input int stall_k,
                             input bit keep_valid, input string nm,
                             output int wait_cyc, output int first_ov);
        int c;
        int k;
        int stall;
        int scramble[8];
        set_x(xs);
        in_valid = 1'b1;
        c = 0;
        while (!in_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        wait_cyc = c;
        check({nm, "_in_ready_before_accept"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            in_valid = 1'b0;
            for (int i = 0; i < 8; i++) scramble[i] = -1;
            set_x(scramble);
        end
        c = 0;
        k = 0;
        stall = 0;
        first_ov = -1;
        while (k < 8 && c < 400) begin
            @(negedge clk);
            c++;
            if (out_valid) begin
                if (first_ov < 0) first_ov = c;
                if (k == stall_k && stall < 20) begin
                    out_ready = 1'b0;
                    check($sformatf("%s_stall_dout_k%0d", nm, k), int'(dout), ex[k]);
                    check($sformatf("%s_stall_kidx", nm), int'(kidx), k);
                    check($sformatf("%s_stall_in_ready", nm), int'(in_ready), 0);
                    stall++;
                end else begin
                    out_ready = 1'b1;
                    check($sformatf("%s_dout_k%0d", nm, k), int'(dout), ex[k]);
                    check($sformatf("%s_kidx_k%0d", nm, k), int'(kidx), k);
                    check($sformatf("%s_last_k%0d", nm, k), int'(last), (k == 7) ? 1 : 0);
                    k++;
                end
            end else begin
                out_ready = 1'b1;
            end
        end
        check({nm, "_coeff_count"}, k, 8);
        @(negedge clk);
        check({nm, "_in_ready_after_last"}, int'(in_ready), 1);
        check({nm, "_out_valid_after_last"}, int'(out_valid), 0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs[8];
        int ex[8];
        int wc;
        int fo;
        int xa[8];
        int xb[8];
        int c;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) xs[i] = 0;
        set_x(xs);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_dout",      int'(dout),      0);
        check("rst_kidx",      int'(kidx),      0);
        check("rst_last",      int'(last),      0);
        rstn = 1'b1;

        // All samples 100: only the DC term survives.
        for (int i = 0; i < 8; i++) xs[i] = 100;
        ex = '{281, 0, 0, 0, 0, 0, 0, 0};
        run_block(xs, ex, -1, 1'b0, "dc100", wc, fo);
        check("dc100_first_out_valid_cycle", fo, 9);

        // Impulse at n=0 with a 20-cycle stall on X3.
        xs = '{1000, 0, 0, 0, 0, 0, 0, 0};
        ex = '{352, 492, 461, 414, 352, 281, 188, 94};
        run_block(xs, ex, 3, 1'b0, "imp", wc, fo);

        // Most negative input: DC term saturates.
        for (int i = 0; i < 8; i++) xs[i] = -1024;
        ex = '{-2048, 0, 0, 0, 0, 0, 0, 0};
        run_block(xs, ex, -1, 1'b0, "neg_sat", wc, fo);

        // Reset while computing X4, then a clean block.
        xs = '{300, -200, 100, 50, -75, 25, 10, -5};
        set_x(xs);
        in_valid = 1'b1;
        c = 0;
        while (!in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready",  int'(in_ready),  1);
        check("midrst_kidx",      int'(kidx),      0);
        check("midrst_dout",      int'(dout),      0);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_no_stale_output", int'(out_valid), 0);
        xs = '{-500, 250, 125, -60, 30, 700, -900, 10};
        for (int k = 0; k < 8; k++) ex[k] = model(xs, k);
        run_block(xs, ex, -1, 1'b0, "post_rst", wc, fo);
        check("post_rst_first_out_valid_cycle", fo, 9);

        // Back-to-back blocks with in_valid held high.
        xa = '{200, -150, 300, 50, -400, 120, 0, -75};
        for (int k = 0; k < 8; k++) ex[k] = model(xa, k);
        run_block(xa, ex, -1, 1'b1, "b2b_a", wc, fo);
        xb = '{16, -16, 32, 0, 8, -8, 24, 4};
        for (int k = 0; k < 8; k++) ex[k] = model(xb, k);
        run_block(xb, ex, -1, 1'b1, "b2b_b", wc, fo);
        check("b2b_accept_immediate", wc, 0);
        check("b2b_b_first_out_valid_cycle", fo, 9);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            real d;
            d = real'(ex[k]) - float_dct(xb, k);
            check($sformatf("b2b_b_float_k%0d_within_1lsb", k),
                  (d <= 1.0 && d >= -1.0) ? 1 : 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
